// File: rtl/memory_island_pkg.sv
`default_nettype none
// ============================================================================
// memory_island_pkg : shared response-tag type and index-width helper
// Rev 1.0
// ============================================================================
package memory_island_pkg;

    // Tag idx field is sized for the largest supported requester count.
    localparam int unsigned MaxIdxWidth = 8;

    function automatic int unsigned calc_idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                   valid;
        logic                   is_wide;
        logic [MaxIdxWidth-1:0] idx;
    } rsp_tag_t;

endpackage
`default_nettype wire

// File: rtl/memory_island_rsp_tracker.sv
`default_nettype none
// ============================================================================
// memory_island_rsp_tracker : fixed-depth delay line for bank response tags
// Rev 1.0
// ============================================================================
module memory_island_rsp_tracker
    import memory_island_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  rsp_tag_t tag_i,
    output rsp_tag_t tag_o
);

    rsp_tag_t [Depth-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int unsigned i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[Depth-1];

endmodule
`default_nettype wire

// File: rtl/memory_island_bank_arbiter.sv
`default_nettype none
// ============================================================================
// memory_island_bank_arbiter : shares one SRAM bank between round-robin narrow
// ports and a wide slice with starvation-based priority. Rev 1.0
// ============================================================================
module memory_island_bank_arbiter
    import memory_island_pkg::*;
#(
    parameter  int unsigned NumNarrowReq     = 4,
    parameter  int unsigned DataWidth        = 32,
    parameter  int unsigned BankAddrWidth    = 10,
    parameter  int unsigned BankLatency      = 1,
    parameter  int unsigned WidePriorityWait = 1,
    localparam int unsigned StrbWidth        = DataWidth / 8,
    localparam int unsigned IdxWidth         = calc_idx_width(NumNarrowReq)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [NumNarrowReq-1:0]                     narrow_req_i,
    output logic [NumNarrowReq-1:0]                     narrow_gnt_o,
    input  logic [NumNarrowReq-1:0][BankAddrWidth-1:0]  narrow_addr_i,
    input  logic [NumNarrowReq-1:0]                     narrow_we_i,
    input  logic [NumNarrowReq-1:0][DataWidth-1:0]      narrow_wdata_i,
    input  logic [NumNarrowReq-1:0][StrbWidth-1:0]      narrow_strb_i,
    output logic [NumNarrowReq-1:0]                     narrow_rvalid_o,
    output logic [DataWidth-1:0]                        narrow_rdata_o,
    input  logic                                        wide_req_i,
    output logic                                        wide_gnt_o,
    input  logic [BankAddrWidth-1:0]                    wide_addr_i,
    input  logic                                        wide_we_i,
    input  logic [DataWidth-1:0]                        wide_wdata_i,
    input  logic [StrbWidth-1:0]                        wide_strb_i,
    output logic                                        wide_rvalid_o,
    output logic [DataWidth-1:0]                        wide_rdata_o,
    output logic                                        bank_req_o,
    output logic                                        bank_we_o,
    output logic [BankAddrWidth-1:0]                    bank_addr_o,
    output logic [DataWidth-1:0]                        bank_wdata_o,
    output logic [StrbWidth-1:0]                        bank_strb_o,
    input  logic [DataWidth-1:0]                        bank_rdata_i
);

    localparam int unsigned CntWidth =
        (WidePriorityWait <= 1) ? 1 : $clog2(WidePriorityWait + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(WidePriorityWait);

    logic [IdxWidth-1:0] rr_q, rr_d;
    logic [CntWidth-1:0] wait_q, wait_d;

    logic                narrow_any;
    logic                narrow_found;
    logic [IdxWidth-1:0] sel_idx;
    logic [IdxWidth-1:0] rr_next;
    int unsigned         cand;
    logic                wide_prio;
    logic                wide_gnt;
    logic                narrow_win;
    rsp_tag_t            tag_in, tag_out;

    // First requester at or above rr_q, wrapping past the top index.
    always_comb begin
        narrow_any   = |narrow_req_i;
        narrow_found = 1'b0;
        sel_idx      = '0;
        cand         = 0;
        for (int unsigned i = 0; i < NumNarrowReq; i++) begin
            cand = (32'(rr_q) + i) % NumNarrowReq;
            if (!narrow_found && narrow_req_i[cand[IdxWidth-1:0]]) begin
                narrow_found = 1'b1;
                sel_idx      = cand[IdxWidth-1:0];
            end
        end
    end

    assign rr_next    = (32'(sel_idx) == NumNarrowReq - 1) ? '0 : sel_idx + IdxWidth'(1);
    assign wide_prio  = wide_req_i && (WidePriorityWait != 0) && (wait_q == CntMax);
    assign wide_gnt   = wide_req_i && (wide_prio || !narrow_any);
    assign narrow_win = narrow_any && !wide_gnt;

    assign wide_gnt_o   = wide_gnt;
    assign narrow_gnt_o = narrow_win ? (NumNarrowReq'(1) << sel_idx) : '0;
    assign bank_req_o   = wide_gnt || narrow_win;

    always_comb begin
        bank_we_o    = 1'b0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_strb_o  = '0;
        if (wide_gnt) begin
            bank_we_o    = wide_we_i;
            bank_addr_o  = wide_addr_i;
            bank_wdata_o = wide_wdata_i;
            bank_strb_o  = wide_strb_i;
        end else if (narrow_win) begin
            bank_we_o    = narrow_we_i[sel_idx];
            bank_addr_o  = narrow_addr_i[sel_idx];
            bank_wdata_o = narrow_wdata_i[sel_idx];
            bank_strb_o  = narrow_strb_i[sel_idx];
        end
    end

    always_comb begin
        rr_d   = narrow_win ? rr_next : rr_q;
        wait_d = wait_q;
        if ((WidePriorityWait == 0) || !wide_req_i || wide_gnt) begin
            wait_d = '0;
        end else if (wait_q != CntMax) begin
            wait_d = wait_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            wait_q <= '0;
        end else begin
            rr_q   <= rr_d;
            wait_q <= wait_d;
        end
    end

    always_comb begin
        tag_in         = '0;
        tag_in.valid   = bank_req_o;
        tag_in.is_wide = wide_gnt;
        tag_in.idx     = MaxIdxWidth'(sel_idx);
    end

    memory_island_rsp_tracker #(
        .Depth (BankLatency)
    ) u_rsp_tracker (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tag_i  (tag_in),
        .tag_o  (tag_out)
    );

    assign wide_rvalid_o   = tag_out.valid && tag_out.is_wide;
    assign narrow_rvalid_o = (tag_out.valid && !tag_out.is_wide) ?
                             (NumNarrowReq'(1) << tag_out.idx) : '0;

    // Bank read data is fanned out unregistered; rvalid tells who owns it.
    assign narrow_rdata_o = bank_rdata_i;
    assign wide_rdata_o   = bank_rdata_i;

endmodule
`default_nettype wire

// File: doc/memory_island_bank_arbiter.md
Name: memory_island_bank_arbiter

Overview:
Per-bank scheduler for the memory island. It shares one SRAM bank (word width = narrow data width) between NumNarrowReq narrow requesters and one wide-slice requester, which is the bank-aligned part of a wide access. Narrow ports are arbitrated round-robin. The wide slice can win priority over narrow through a starvation counter. Fixed-latency responses are routed back to the granted requester.

Parameters:
NumNarrowReq, 4, number of narrow requesters (>=1)
DataWidth, 32, bank word width in bits
StrbWidth, DataWidth/8, byte strobes (derived, do not override)
BankAddrWidth, 10, word address width into the bank
BankLatency, 1, cycles from bank_req_o to valid bank_rdata_i (>=1)
WidePriorityWait, 1, wide-wait cycles before wide preempts narrow; 0 = narrow always has priority
IdxWidth, max(1,$clog2(NumNarrowReq)), derived

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
narrow_req_i  in  NumNarrowReq  narrow request
narrow_gnt_o  out  NumNarrowReq  narrow grant, combinational
narrow_addr_i  in  NumNarrowReq x BankAddrWidth  word address
narrow_we_i  in  NumNarrowReq  write enable
narrow_wdata_i  in  NumNarrowReq x DataWidth  write data
narrow_strb_i  in  NumNarrowReq x StrbWidth  byte strobes
narrow_rvalid_o  out  NumNarrowReq  response valid
narrow_rdata_o  out  DataWidth  read data, shared by all narrow ports
wide_req_i  in  1  wide-slice request
wide_gnt_o  out  1  wide-slice grant
wide_addr_i  in  BankAddrWidth  address
wide_we_i  in  1  write enable
wide_wdata_i  in  DataWidth  write data
wide_strb_i  in  StrbWidth  strobes
wide_rvalid_o  out  1  response valid
wide_rdata_o  out  DataWidth  read data
bank_req_o  out  1  bank access
bank_we_o  out  1  bank write
bank_addr_o  out  BankAddrWidth  bank address
bank_wdata_o  out  DataWidth  bank write data
bank_strb_o  out  StrbWidth  bank byte enables
bank_rdata_i  in  DataWidth  bank read data

Behaviour:
- Clocking: single clock clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: rr_ptr=0, wait_cnt=0, response pipeline all invalid. With no requests, all gnt/rvalid/bank_req outputs are 0.
- Handshake: a grant is combinational in the cycle of the request. A transfer occurs when req&gnt. Requesters do not need to hold req after a grant. At most one grant per cycle; bank_req_o = OR of all grants.
- Priority decision (combinational):
  - wide_prio = wide_req_i & (WidePriorityWait!=0) & (wait_cnt>=WidePriorityWait).
  - If wide_prio, or no narrow_req_i is set: grant wide when wide_req_i.
  - Otherwise grant one narrow port.
- Narrow round-robin: grant the first requesting index searching upward from rr_ptr, with wrap-around (NumNarrowReq-1 to 0). On a narrow grant, rr_ptr <= (idx+1) mod NumNarrowReq. rr_ptr is unchanged otherwise. With NumNarrowReq=1, rr_ptr stays 0.
- Starvation counter:
  - If wide_req_i & !wide_gnt_o: wait_cnt increments, saturating at WidePriorityWait.
  - If wide_gnt_o, or !wide_req_i: wait_cnt <= 0.
  - With WidePriorityWait=0 the counter is tied to 0.
- Bank mux: bank_we/addr/wdata/strb take the granted source's fields. Undefined when no grant; drive 0.
- Response tracking: a shift register of depth BankLatency carries {valid, is_wide, idx}. Stage 0 is loaded each cycle with {bank_req_o, wide granted, narrow idx}.
  - At the tail: wide_rvalid_o = valid&is_wide; narrow_rvalid_o[idx] = valid&!is_wide.
  - Reads and writes both produce exactly one rvalid, BankLatency cycles after the grant.
- Response data: narrow_rdata_o = wide_rdata_o = bank_rdata_i, unregistered.
- No backpressure on responses; requesters must always accept.
- Back-to-back grants every cycle are supported (throughput 1/cycle).
- Reset mid-operation: in-flight responses are discarded and no rvalid is emitted after reset. Counter and pointer return to 0.
- Simultaneous events:
  - Wide and narrow request in the same cycle with wide_prio=0: narrow wins, wait_cnt increments.
  - A wide request arriving in the same cycle wait_cnt saturates: preemption takes effect the following cycle.

Decomposition:
- Package memory_island_pkg: the response-tag struct {valid, is_wide, idx} and the helper function computing IdxWidth.
- One sub-module, memory_island_rsp_tracker: parameterised tag delay line of depth BankLatency with async reset.
- The round-robin search stays inline.

Test Plan:
1. Reset, then narrow_req_i=4'b0101 held for 4 cycles -> grants alternate 0,2,0,2. Each narrow_rvalid_o fires exactly BankLatency=1 cycle later with the data from the matching address.
2. WidePriorityWait=1, narrow_req_i=4'b1111 continuous, wide_req_i=1:
   - cycle0: narrow gnt, wait_cnt=1.
   - cycle1: wide gnt.
   - cycle2: narrow again, continuing round-robin order.
3. WidePriorityWait=0, narrow saturating for 20 cycles -> wide_gnt_o stays 0. Dropping all narrow requests -> wide granted the same cycle.
4. Write 0xDEADBEEF with strb=4'b0011 from narrow1, then read from wide at the same address -> wide_rdata_o=0x0000BEEF (bank init 0). The write also yields a narrow_rvalid_o[1] pulse.
5. BankLatency=3, grants issued to wide, n3, n0 on consecutive cycles; assert rst_ni low on the second cycle -> no rvalid observed after reset, rr_ptr=0, wait_cnt=0.
6. NumNarrowReq=1, wide and narrow each requesting every other cycle -> no lost or duplicated rvalid. Total rvalid count equals total grant count.
